stream_mix_circuit: RTL and testbench
=====================================

Name: stream_mix_circuit

Overview:
- 8-bit, 3-register pipeline that scrambles an incoming byte stream.
- Each output byte is a running modulo-256 sum of past inputs XORed with a nibble-swapped copy of the previous input.
- Driven by an upstream 8-bit counter. Its output feeds an external seed-XOR / accumulate / rotate checksum path.

Parameters:
- WIDTH, 8, datapath width in bits. Nibble swap is defined for WIDTH = 8 only.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  synchronous, active-low reset. Sampled only at the rising edge of clk.
- cct_input  input  8  input byte, sampled every rising edge.
- cct_output  output  8  registered scrambled byte.

Behaviour:
- Single clock domain. Reset is synchronous and active-low, and it is the only control input.
- Registers: in_r[7:0], acc[7:0], out_r[7:0]. cct_output = out_r, driven directly, with no combinational path from cct_input.
- Reset (clear = 0 at a rising edge):
  - in_r, acc and out_r all load 8'h00.
  - Reset overrides all other updates on that edge.
- Normal operation (clear = 1 at a rising edge). All right-hand sides use pre-edge register values:
  - in_r <= cct_input
  - acc <= (acc + in_r) mod 256. Carry is discarded; there is no saturation.
  - out_r <= acc XOR {in_r[3:0], in_r[7:4]}
- No enable or hold input: the pipeline advances on every non-reset edge.
  - A constant cct_input keeps acc incrementing by that value every cycle.
- Latency:
  - A byte sampled at edge k enters acc at edge k+1.
  - Its nibble-swapped form appears on cct_output after edge k+1.
  - Its contribution to the accumulated term appears on cct_output after edge k+2.
- Pulses on clear that do not span a rising edge have no effect. There is no asynchronous path.
- Reset mid-stream: all state returns to zero on that edge and the pipeline restarts as from power-up. No residual accumulation is kept.
- Wrap-around: acc 8'hFF + 8'h01 gives 8'h00. Holding cct_input = 8'hFF decrements acc by 1 each cycle.
- Power-up: register contents are undefined until the first reset edge. The bench applies reset before checking.

Test Plan:
- Reset: clear = 0 for 2 edges with cct_input = 8'h5A → cct_output = 8'h00, and internal acc = 8'h00.
- Constant input: after reset, hold cct_input = 8'h01 with clear = 1 → cct_output after edges 1..5 is 00, 10, 11, 12, 13.
- Nibble swap: after reset, cct_input = 8'hA5 for one edge, then 8'h00 → cct_output after edge 2 is 8'h5A, and after edge 3 is 8'hA5 (acc = A5, in_r = 00).
- Wrap: after reset, hold cct_input = 8'hFF → acc after edges 2, 3, 4 is FF, FE, FD. cct_output after edges 1..4 is 00, FF, 00, 01.
- Mid-run reset: run the counting stream 0,1,2,… for 20 cycles, then one edge with clear = 0 → all registers are zero after that edge, and the sequence then repeats the post-reset values exactly.
- Glitch immunity: a clear = 0 pulse of half a clock period placed between rising edges → no change to the cct_output sequence versus the unglitched run.

Source files
------------

// File: rtl/stream_mix_circuit.sv
// Byte-stream scrambler: out = running sum of past inputs XOR nibble-swapped previous input.
// Latency: input sampled at edge k shows swapped on cct_output after k+1, summed after k+2.
// Backpressure: none; the pipeline advances on every non-reset rising edge.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   clear      - synchronous active-low reset, sampled only at the rising edge
//   cct_input  - input byte, sampled every rising edge
//   cct_output - registered scrambled byte (no combinational path from cct_input)
module stream_mix_circuit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] cct_input,
  output logic [WIDTH-1:0] cct_output
);

  // The swap exchanges the two halves of the word; for the 8-bit datapath
  // this is the nibble swap.
  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] in_q,  in_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] in_swapped;

  assign in_swapped = {in_q[HALF-1:0], in_q[WIDTH-1:HALF]};

  always_comb begin
    in_d  = cct_input;
    // Modulo-2^WIDTH accumulate: the carry out simply falls off, so an
    // all-ones input acts as a decrement by one.
    acc_d = acc_q + in_q;
    // Uses the pre-edge accumulator, which is why an input's contribution to
    // the sum reaches the output one cycle after its swapped copy does.
    out_d = acc_q ^ in_swapped;
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      in_q  <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign cct_output = out_q;

endmodule

// File: tb/tb_stream_mix_circuit.sv
module tb_stream_mix_circuit;

  logic       clk;
  logic       clear;
  logic [7:0] cct_input;
  logic [7:0] cct_output;

  int checks = 0;
  int errors = 0;

  // Reference model state (updated once per rising edge, pre-edge values on RHS)
  logic [7:0] m_in, m_acc, m_out;
  logic [7:0] first_run [20];

  stream_mix_circuit #(.WIDTH(8)) dut (
    .clk        (clk),
    .clear      (clear),
    .cct_input  (cct_input),
    .cct_output (cct_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic clr, input logic [7:0] din);
    logic [7:0] n_in, n_acc, n_out;
    if (!clr) begin
      n_in = 8'h00; n_acc = 8'h00; n_out = 8'h00;
    end else begin
      n_in  = din;
      n_acc = m_acc + m_in;
      n_out = m_acc ^ {m_in[3:0], m_in[7:4]};
    end
    m_in = n_in; m_acc = n_acc; m_out = n_out;
  endtask

  // Drive inputs, optionally glitch clear low for half a period between edges,
  // then advance one rising edge and settle 1 time unit past it.
  task automatic step(input logic [7:0] din, input logic clr, input bit glitch);
    cct_input = din;
    clear     = clr;
    if (glitch) begin
      #2 clear = 1'b0;
      #5 clear = 1'b1;
    end
    @(posedge clk);
    #1;
    model_step(clear, din);
  endtask

  initial begin
    clear     = 1'b0;
    cct_input = 8'h5A;
    m_in = 8'h00; m_acc = 8'h00; m_out = 8'h00;

    // Reset: two edges low with non-zero input
    step(8'h5A, 1'b0, 1'b0);
    step(8'h5A, 1'b0, 1'b0);
    check("reset_out", cct_output, 8'h00);
    check("reset_acc", dut.acc_q, 8'h00);
    check("reset_in",  dut.in_q,  8'h00);

    // Constant input 01
    step(8'h01, 1'b1, 1'b0); check("const_e1", cct_output, 8'h00);
    step(8'h01, 1'b1, 1'b0); check("const_e2", cct_output, 8'h10);
    step(8'h01, 1'b1, 1'b0); check("const_e3", cct_output, 8'h11);
    step(8'h01, 1'b1, 1'b0); check("const_e4", cct_output, 8'h12);
    step(8'h01, 1'b1, 1'b0); check("const_e5", cct_output, 8'h13);

    // Nibble swap: A5 for one edge then 00
    step(8'h00, 1'b0, 1'b0);
    step(8'hA5, 1'b1, 1'b0); check("swap_e1", cct_output, 8'h00);
    step(8'h00, 1'b1, 1'b0); check("swap_e2", cct_output, 8'h5A);
    step(8'h00, 1'b1, 1'b0); check("swap_e3", cct_output, 8'hA5);
    check("swap_acc", dut.acc_q, 8'hA5);

    // Wrap-around with FF held
    step(8'h00, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0); check("wrap_out1", cct_output, 8'h00);
    step(8'hFF, 1'b1, 1'b0); check("wrap_out2", cct_output, 8'hFF);
    check("wrap_acc2", dut.acc_q, 8'hFF);
    step(8'hFF, 1'b1, 1'b0); check("wrap_out3", cct_output, 8'h00);
    check("wrap_acc3", dut.acc_q, 8'hFE);
    step(8'hFF, 1'b1, 1'b0); check("wrap_out4", cct_output, 8'h01);
    check("wrap_acc4", dut.acc_q, 8'hFD);

    // Counting stream, 20 cycles, against the model
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(8'(i), 1'b1, 1'b0);
      first_run[i] = m_out;
      check($sformatf("count_%0d", i), cct_output, m_out);
    end
    // Spot-check the model against hand values: after edge 3 out = 1 ^ 0x20
    check("count_hand3", first_run[3], 8'h21);
    check("count_hand4", first_run[4], 8'h33);

    // Mid-run reset for one edge
    step(8'h77, 1'b0, 1'b0);
    check("midrst_out", cct_output, 8'h00);
    check("midrst_acc", dut.acc_q, 8'h00);
    check("midrst_in",  dut.in_q,  8'h00);
    for (int i = 0; i < 20; i++) begin
      step(8'(i), 1'b1, 1'b0);
      check($sformatf("repeat_%0d", i), cct_output, first_run[i]);
    end

    // Glitch immunity: half-period low pulses between edges
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(8'(i), 1'b1, (i == 4) || (i == 9));
      check($sformatf("glitch_%0d", i), cct_output, first_run[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
